// File: rtl/arcade_input_mapper.sv
// Arcade input glue: PS/2 key latches and HPS joystick words merged into per-player controls,
// with optional screen-rotation remap, opposing-direction cleanup and fixed-width coin pulses.
// Optional build macro: START_COINS_EN (any start press also requests a coin for player 0).
module arcade_input_mapper #(
    parameter int PLAYERS    = 2,
    parameter int BTNS       = 2,
    parameter int COIN_PULSE = 1200000
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [10:0]             ps2_key,
    input  logic [16*PLAYERS-1:0]   joy_in,
    input  logic                    rotate_en,
    input  logic                    rotate_ccw,
    output logic [PLAYERS-1:0]      up,
    output logic [PLAYERS-1:0]      down,
    output logic [PLAYERS-1:0]      left,
    output logic [PLAYERS-1:0]      right,
    output logic [PLAYERS*BTNS-1:0] fire,
    output logic [PLAYERS-1:0]      start,
    output logic [PLAYERS-1:0]      coin
);
    localparam int CW = $clog2(COIN_PULSE + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(COIN_PULSE - 1);

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} coin_state_e;

    logic                  old_tog_q, old_tog_d;
    logic                  key_event;
    logic [1:0][9:0]       key_hit;
    logic [1:0][3:0]       kdir_q, kdir_d;
    logic [1:0][BTNS-1:0]  kfire_q, kfire_d;
    logic [1:0]            kstart_q, kstart_d;
    logic [1:0]            kcoin_q, kcoin_d;

    logic [PLAYERS-1:0]      raw_up, raw_down, raw_left, raw_right, raw_start, raw_coin;
    logic [PLAYERS*BTNS-1:0] raw_fire;
    logic [PLAYERS-1:0]      rot_up, rot_down, rot_left, rot_right;
    logic [PLAYERS-1:0]      coin_req;

    logic [PLAYERS-1:0]      up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
    logic [PLAYERS-1:0]      start_q, start_d, coin_q, coin_d;
    logic [PLAYERS*BTNS-1:0] fire_q, fire_d;
    coin_state_e             coin_state_q [PLAYERS];
    coin_state_e             coin_state_d [PLAYERS];
    logic [CW-1:0]           cnt_q [PLAYERS];
    logic [CW-1:0]           cnt_d [PLAYERS];

    // Joystick spare bits, the extended flag and unused fire slots are deliberately ignored.
    logic unused_inputs;
    assign unused_inputs = ^{joy_in, ps2_key[8], key_hit};

    assign old_tog_d = ps2_key[10];
    assign key_event = ps2_key[10] ^ old_tog_q;

    // Hit index per player: 0 right, 1 left, 2 down, 3 up, 4..7 fire0..3, 8 start, 9 coin.
    always_comb begin
        key_hit = '0;
        case (ps2_key[7:0])
            8'h74:        key_hit[0][0] = 1'b1;
            8'h6B:        key_hit[0][1] = 1'b1;
            8'h72:        key_hit[0][2] = 1'b1;
            8'h75:        key_hit[0][3] = 1'b1;
            8'h14, 8'h29: key_hit[0][4] = 1'b1;
            8'h11:        key_hit[0][5] = 1'b1;
            8'h12:        key_hit[0][6] = 1'b1;
            8'h1A:        key_hit[0][7] = 1'b1;
            8'h16, 8'h05: key_hit[0][8] = 1'b1;
            8'h2E:        key_hit[0][9] = 1'b1;
            8'h34:        key_hit[1][0] = 1'b1;
            8'h23:        key_hit[1][1] = 1'b1;
            8'h2B:        key_hit[1][2] = 1'b1;
            8'h2D:        key_hit[1][3] = 1'b1;
            8'h1C:        key_hit[1][4] = 1'b1;
            8'h1B:        key_hit[1][5] = 1'b1;
            8'h15:        key_hit[1][6] = 1'b1;
            8'h1D:        key_hit[1][7] = 1'b1;
            8'h1E, 8'h06: key_hit[1][8] = 1'b1;
            8'h36:        key_hit[1][9] = 1'b1;
            default:      ;
        endcase
    end

    always_comb begin
        kdir_d   = kdir_q;
        kfire_d  = kfire_q;
        kstart_d = kstart_q;
        kcoin_d  = kcoin_q;
        if (key_event) begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < 4; k++)
                    if (key_hit[p][k]) kdir_d[p][k] = ps2_key[9];
                for (int b = 0; b < BTNS; b++)
                    if (key_hit[p][4+b]) kfire_d[p][b] = ps2_key[9];
                if (key_hit[p][8]) kstart_d[p] = ps2_key[9];
                if (key_hit[p][9]) kcoin_d[p] = ps2_key[9];
            end
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_raw
        logic [3:0]      kdir;
        logic [BTNS-1:0] kfire;
        logic            kstart, kcoin;
        if (p < 2) begin : g_key
            assign kdir   = kdir_q[p];
            assign kfire  = kfire_q[p];
            assign kstart = kstart_q[p];
            assign kcoin  = kcoin_q[p];
        end else begin : g_joy_only
            assign kdir   = '0;
            assign kfire  = '0;
            assign kstart = 1'b0;
            assign kcoin  = 1'b0;
        end
        assign raw_right[p]               = joy_in[16*p]          | kdir[0];
        assign raw_left[p]                = joy_in[16*p+1]        | kdir[1];
        assign raw_down[p]                = joy_in[16*p+2]        | kdir[2];
        assign raw_up[p]                  = joy_in[16*p+3]        | kdir[3];
        assign raw_fire[p*BTNS +: BTNS]   = joy_in[16*p+4 +: BTNS] | kfire;
        assign raw_start[p]               = joy_in[16*p+4+BTNS]   | kstart;
        assign raw_coin[p]                = joy_in[16*p+5+BTNS]   | kcoin;
    end

    // Rotation first, then opposing-direction cancellation on the rotated view.
    always_comb begin
        rot_up    = raw_up;
        rot_down  = raw_down;
        rot_left  = raw_left;
        rot_right = raw_right;
        if (rotate_en) begin
            if (rotate_ccw) begin
                rot_up    = raw_right;
                rot_down  = raw_left;
                rot_left  = raw_up;
                rot_right = raw_down;
            end else begin
                rot_up    = raw_left;
                rot_down  = raw_right;
                rot_left  = raw_down;
                rot_right = raw_up;
            end
        end
        up_d    = rot_up & ~rot_down;
        down_d  = rot_down & ~rot_up;
        left_d  = rot_left & ~rot_right;
        right_d = rot_right & ~rot_left;
        fire_d  = raw_fire;
        start_d = raw_start;
    end

    always_comb begin
        coin_req = raw_coin;
`ifdef START_COINS_EN
        coin_req[0] = raw_coin[0] | (|raw_start);
`else
        coin_req[0] = raw_coin[0];
`endif
    end

    // A held coin request yields a single pulse; HOLD waits for release before re-arming.
    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            coin_state_d[p] = coin_state_q[p];
            cnt_d[p]        = cnt_q[p];
            coin_d[p]       = coin_q[p];
            case (coin_state_q[p])
                IDLE: if (coin_req[p]) begin
                    coin_state_d[p] = PULSE;
                    cnt_d[p]        = CNT_LOAD;
                    coin_d[p]       = 1'b1;
                end
                PULSE: if (cnt_q[p] == '0) begin
                    coin_d[p]       = 1'b0;
                    coin_state_d[p] = coin_req[p] ? HOLD : IDLE;
                end else begin
                    cnt_d[p] = cnt_q[p] - 1'b1;
                end
                HOLD: if (!coin_req[p]) coin_state_d[p] = IDLE;
                default: coin_state_d[p] = IDLE;
            endcase
        end
    end

    // The toggle tracker keeps following the key port during reset so release sees no event.
    always_ff @(posedge clk_sys) begin
        old_tog_q <= old_tog_d;
        if (!reset_n) begin
            kdir_q   <= '0;
            kfire_q  <= '0;
            kstart_q <= '0;
            kcoin_q  <= '0;
            up_q     <= '0;
            down_q   <= '0;
            left_q   <= '0;
            right_q  <= '0;
            fire_q   <= '0;
            start_q  <= '0;
            coin_q   <= '0;
            for (int p = 0; p < PLAYERS; p++) begin
                coin_state_q[p] <= IDLE;
                cnt_q[p]        <= '0;
            end
        end else begin
            kdir_q   <= kdir_d;
            kfire_q  <= kfire_d;
            kstart_q <= kstart_d;
            kcoin_q  <= kcoin_d;
            up_q     <= up_d;
            down_q   <= down_d;
            left_q   <= left_d;
            right_q  <= right_d;
            fire_q   <= fire_d;
            start_q  <= start_d;
            coin_q   <= coin_d;
            for (int p = 0; p < PLAYERS; p++) begin
                coin_state_q[p] <= coin_state_d[p];
                cnt_q[p]        <= cnt_d[p];
            end
        end
    end

    assign up    = up_q;
    assign down  = down_q;
    assign left  = left_q;
    assign right = right_q;
    assign fire  = fire_q;
    assign start = start_q;
    assign coin  = coin_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper (2 players, 2 buttons, 4-cycle coin pulse).
module tb_arcade_input_mapper;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [31:0] joy_in;
    logic        rotate_en, rotate_ccw;
    logic [1:0]  up, down, left, right, start, coin;
    logic [3:0]  fire;

    int n_checks = 0;
    int n_fail   = 0;

    arcade_input_mapper #(.PLAYERS(2), .BTNS(2), .COIN_PULSE(4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy_in(joy_in),
        .rotate_en(rotate_en), .rotate_ccw(rotate_ccw),
        .up(up), .down(down), .left(left), .right(right),
        .fire(fire), .start(start), .coin(coin)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [31:0] joy;
        logic        rot_en;
        logic        rot_ccw;
        logic [1:0]  e_up, e_down, e_left, e_right;
        logic [3:0]  e_fire;
        logic [1:0]  e_start;
    } vec_t;

    vec_t vecs [20];

    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        joy_in     = v.joy;
        rotate_en  = v.rot_en;
        rotate_ccw = v.rot_ccw;
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic count_coin(input int cycles, output int high, output int rises, output int first);
        logic prev;
        prev  = 1'b0;
        high  = 0;
        rises = 0;
        first = -1;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (coin[0]) begin
                high++;
                if (!prev) rises++;
                if (first < 0) first = i;
            end
            prev = coin[0];
        end
    endtask

    initial begin
        int high, rises, first;

        //          joy            en    ccw   up     down   left   right  fire     start
        vecs[0]  = '{32'h0000_0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[1]  = '{32'h0000_0008, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[2]  = '{32'h0000_0004, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[3]  = '{32'h0000_0002, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 2'b00};
        vecs[4]  = '{32'h0000_0001, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 2'b00};
        vecs[5]  = '{32'h0000_0030, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0011, 2'b00};
        vecs[6]  = '{32'h0040_0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b10};
        vecs[7]  = '{32'h0010_0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0100, 2'b00};
        vecs[8]  = '{32'h0020_0040, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1000, 2'b01};
        vecs[9]  = '{32'h0000_0003, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[10] = '{32'h0000_000C, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[11] = '{32'h0000_0002, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[12] = '{32'h0000_0002, 1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[13] = '{32'h0000_0008, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 2'b00};
        vecs[14] = '{32'h0000_0008, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 2'b00};
        vecs[15] = '{32'h0000_0001, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[16] = '{32'h0000_0004, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 2'b00};
        vecs[17] = '{32'h0000_0003, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00};
        vecs[18] = '{32'h0009_0006, 1'b0, 1'b0, 2'b10, 2'b01, 2'b01, 2'b10, 4'b0000, 2'b00};
        vecs[19] = '{32'h0008_0000, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 4'b0000, 2'b00};

        // Reset with the toggle bit high and a mapped press on the bus: release must not see an event.
        reset_n    = 1'b0;
        ps2_key    = {1'b1, 1'b1, 1'b0, 8'h1C};
        joy_in     = '0;
        rotate_en  = 1'b0;
        rotate_ccw = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output($sformatf("reset_idle_%0d", i), {18'b0, up, down, left, right, fire, start, coin}, 32'h0);
        end

        for (int i = 0; i < 20; i++) begin
            apply_stimulus(vecs[i]);
            tick();
            check_output($sformatf("vec%0d", i), {18'b0, up, down, left, right, fire, start},
                         {18'b0, vecs[i].e_up, vecs[i].e_down, vecs[i].e_left, vecs[i].e_right,
                          vecs[i].e_fire, vecs[i].e_start});
        end
        joy_in    = '0;
        rotate_en = 1'b0;
        rotate_ccw = 1'b0;
        repeat (2) tick();

        // P2 fire0 via key A: latched at the first edge, visible after the second.
        send_key(1'b1, 1'b0, 8'h1C);
        tick();
        check_output("key_a_lat1", {28'b0, fire}, 32'h0);
        tick();
        check_output("key_a_press", {28'b0, fire}, 32'h4);
        send_key(1'b0, 1'b0, 8'h1C);
        repeat (2) tick();
        check_output("key_a_release", {28'b0, fire}, 32'h0);

        // Left+right cancel while an extended up-arrow key still drives up.
        joy_in = 32'h0000_0003;
        send_key(1'b1, 1'b1, 8'h75);
        tick();
        check_output("clean_lat1", {26'b0, up, left, right}, 32'h0);
        tick();
        check_output("clean_up_key", {26'b0, up, left, right}, {26'b0, 2'b01, 2'b00, 2'b00});
        send_key(1'b0, 1'b1, 8'h75);
        joy_in = '0;
        repeat (2) tick();
        check_output("up_key_release", {30'b0, up}, 32'h0);

        // Held joystick coin: one 4-cycle pulse, then another after release and reassert.
        joy_in = 32'h0000_0080;
        count_coin(20, high, rises, first);
        check_output("coin1_high", high, 4);
        check_output("coin1_pulses", rises, 1);
        check_output("coin1_latency", first, 0);
        joy_in = '0;
        repeat (2) tick();
        joy_in = 32'h0000_0080;
        count_coin(20, high, rises, first);
        check_output("coin2_high", high, 4);
        check_output("coin2_pulses", rises, 1);
        check_output("coin_p1_idle", {30'b0, coin[1], 1'b0}, 32'h0);
        joy_in = '0;
        repeat (2) tick();

        // Reset mid-pulse truncates the coin and clears key latches; FSM restarts from IDLE.
        joy_in = 32'h0000_0080;
        send_key(1'b1, 1'b0, 8'h1E);
        repeat (2) tick();
        check_output("pre_reset", {28'b0, coin, start}, {28'b0, 2'b01, 2'b10});
        reset_n = 1'b0;
        tick();
        check_output("in_reset", {28'b0, coin, start}, 32'h0);
        reset_n = 1'b1;
        tick();
        check_output("post_reset", {28'b0, coin, start}, {28'b0, 2'b01, 2'b00});
        joy_in = '0;
        repeat (6) tick();
        check_output("post_reset_done", {30'b0, coin}, 32'h0);
        send_key(1'b0, 1'b0, 8'h1E);
        repeat (2) tick();

        // P2 start key: coins player 0 only when start-to-coin is built in.
        send_key(1'b1, 1'b0, 8'h1E);
        high  = 0;
        rises = 0;
        begin
            logic prev;
            prev = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (coin[0]) begin
                    high++;
                    if (!prev) rises++;
                end
                prev = coin[0];
`ifdef START_COINS_EN
                if (i == 1)
                    check_output("start_coin_edge", {28'b0, coin, start}, {28'b0, 2'b01, 2'b10});
`endif
            end
        end
`ifdef START_COINS_EN
        check_output("start_coin_high", high, 4);
        check_output("start_coin_pulses", rises, 1);
`else
        check_output("start_no_coin", high, 0);
`endif
        check_output("start_level", {30'b0, start}, 32'h2);
        send_key(1'b0, 1'b0, 8'h1E);
        repeat (2) tick();
        check_output("start_release", {30'b0, start}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised successor to the per-core PS/2 keyboard and joystick input glue in the arcade top levels.
- Decodes ps2_key toggle events into latched per-player buttons and merges them with HPS joystick words.
- Applies screen-rotation remapping and cleans opposing directions.
- Produces fixed-width coin pulses. Sits between hps_io and the game core; runs on clk_sys.

Parameters:
- PLAYERS, 2, number of players (1-4); keyboard map exists for P1/P2 only, P3/P4 are joystick-only.
- BTNS, 2, fire buttons per player (1-4).
- COIN_PULSE, 1200000, coin output high time in clk_sys cycles (min 1); counter width = $clog2(COIN_PULSE+1).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  synchronous reset, active low.
- ps2_key  in  11  [10] toggle-per-event, [9] pressed, [8] extended, [7:0] scancode.
- joy_in  in  16*PLAYERS  per-player joystick word; player p at [16p+:16].
- rotate_en  in  1  apply 90-degree direction remap.
- rotate_ccw  in  1  remap direction when rotate_en=1 (0=cw, 1=ccw).
- up, down, left, right  out  PLAYERS  cleaned directions per player.
- fire  out  PLAYERS*BTNS  player p button b at [p*BTNS+b].
- start  out  PLAYERS  start buttons, level.
- coin  out  PLAYERS  coin pulses.

Behaviour:
- Joystick word layout: [0] right, [1] left, [2] down, [3] up, [4+:BTNS] fire, [4+BTNS] start, [5+BTNS] coin.
- Event detect: old_tog register. An event occurs when ps2_key[10] != old_tog. old_tog <= ps2_key[10] every cycle, including during reset, so no spurious event follows reset release.
- On an event, the matching key latch <= ps2_key[9]. Unmapped codes are ignored.
- P1 key map:
  - Arrows 75/72/6B/74, any bit 8.
  - Fire0: ctrl 14 (any bit 8) or space 29. Fire1: alt 11. Fire2: shift 12. Fire3: Z 1A.
  - Start: 1 (16) or F1 (05). Coin: 5 (2E).
- P2 key map:
  - Directions: R 2D up, F 2B down, D 23 left, G 34 right.
  - Fire0-3: A 1C, S 1B, Q 15, W 1D.
  - Start: 2 (1E) or F2 (06). Coin: 6 (36).
- Raw per player = key latch OR joy_in bit. Latches for fire indices >= BTNS are not generated.
- Rotation (rotate_en=1):
  - cw: up<=raw_left, down<=raw_right, left<=raw_down, right<=raw_up.
  - ccw: up<=raw_right, down<=raw_left, left<=raw_up, right<=raw_down.
  - rotate_en=0: identity.
- Opposing-direction clean (after rotation): if up&down both set, both outputs 0; same for left&right.
- Directions, fire and start are registered outputs.
  - Key path latency: toggle presented before edge N, latch at N, output at edge N+1.
  - Joystick path: 1 cycle.
- Coin FSM per player, states IDLE/PULSE/HOLD. req = raw coin.
  - IDLE: on req=1, go to PULSE and load cnt=COIN_PULSE-1; coin=1 from that edge.
  - PULSE: decrement cnt. At cnt==0: coin<=0; go to HOLD if req=1, else IDLE.
  - HOLD: wait for req=0, then IDLE.
  - Requests during PULSE or HOLD are ignored. A held coin gives exactly one pulse.
- Reset (reset_n=0 at an edge): all latches, outputs, counters cleared; FSMs to IDLE. A pulse in progress is truncated.

Optional Feature:
- START_COINS_EN.
  - Defined: any player's raw start also acts as a coin request for player 0 (press-start-to-coin). The start output is still driven normally.
  - Undefined: coin requests come only from coin keys and joystick coin bits.

Test Plan:
- Reset release with ps2_key[10]=1 held -> no event. All outputs 0 for 10 cycles.
- Toggle ps2_key with {pressed=1, code=1C} -> fire[BTNS+0]=1 two edges later. Toggle with pressed=0 -> back to 0.
- COIN_PULSE=4, joy_in[7] (BTNS=2, P0 coin) held 20 cycles -> coin[0] high exactly 4 cycles, once. Release, reassert -> second 4-cycle pulse.
- rotate_en=1, rotate_ccw=0, joy_in[1]=1 -> up[0]=1, others 0. rotate_ccw=1 -> down[0]=1.
- joy_in[0] and joy_in[1] both set -> left[0]=right[0]=0. Adding key 75 press -> up[0]=1 unaffected.
- reset_n=0 for 1 cycle mid coin pulse -> coin[0]=0 next cycle, FSM IDLE. With START_COINS_EN, start key 1E -> coin[0] pulse and start[1]=1.
